// File: rtl/window_shift_param_if.sv
// Bus bundle for window_shift_param: beat inputs (clken/sol/row_in) and the window outputs.
interface window_shift_param_if #(
  parameter int PIXEL_WIDTH = 11,
  parameter int ROWS        = 3,
  parameter int DEPTH       = 258
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                               clken;
  logic                               sol;
  logic [ROWS*PIXEL_WIDTH-1:0]        row_in;
  logic [ROWS*DEPTH*PIXEL_WIDTH-1:0]  win_pixel;
  logic [CNT_W-1:0]                   fill_cnt;
  logic                               win_full;
  logic                               win_valid;

  modport master (
    output clken, sol, row_in,
    input  win_pixel, fill_cnt, win_full, win_valid
  );

  modport slave (
    input  clken, sol, row_in,
    output win_pixel, fill_cnt, win_full, win_valid
  );
endinterface

// File: rtl/window_shift_param.sv
// Multi-row horizontal tap window with shared fill tracking for the disparity path.
// Optional build macro WINDOW_BORDER_REPLICATE_EN: a sol beat floods every tap with row_in.
module window_shift_row #(
  parameter int PW    = 11,
  parameter int DEPTH = 258
) (
  input  logic                clock,
  input  logic                rst,
  input  logic                shift,
  input  logic                load_all,
  input  logic [PW-1:0]       din,
  output logic [DEPTH*PW-1:0] taps
);
  // Tap 0 lives in the MSBs, so a shift is a right move by one pixel.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)          taps <= '0;
    else if (load_all) taps <= {DEPTH{din}};
    else if (shift)    taps <= {din, taps[DEPTH*PW-1:PW]};
  end
endmodule

module window_shift_param #(
  parameter int PIXEL_WIDTH = 11,
  parameter int ROWS        = 3,
  parameter int DEPTH       = 258
) (
  input logic                 clock,
  input logic                 rst,
  window_shift_param_if.slave bus
);
  localparam int PW    = PIXEL_WIDTH;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
`ifdef WINDOW_BORDER_REPLICATE_EN
  localparam logic [CNT_W-1:0] SOL_CNT  = CNT_W'(DEPTH);
`else
  localparam logic [CNT_W-1:0] SOL_CNT  = CNT_W'(1);
`endif

  logic                           repl;
  logic [ROWS-1:0][DEPTH*PW-1:0]  win;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic                           full, vld;

`ifdef WINDOW_BORDER_REPLICATE_EN
  assign repl = bus.clken & bus.sol;
`else
  assign repl = 1'b0;
`endif

  genvar r;
  generate
    for (r = 0; r < ROWS; r++) begin : g_row
      window_shift_row #(.PW(PW), .DEPTH(DEPTH)) u_row (
        .clock    (clock),
        .rst      (rst),
        .shift    (bus.clken),
        .load_all (repl),
        .din      (bus.row_in[r*PW +: PW]),
        .taps     (win[r])
      );
    end
  endgenerate

  // sol restarts the line and wins over saturation
  always_comb begin
    cnt_nxt = cnt;
    if (bus.clken) begin
      if (bus.sol)              cnt_nxt = SOL_CNT;
      else if (cnt != FULL_CNT) cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      full <= 1'b0;
      vld  <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      full <= (cnt_nxt == FULL_CNT);
      vld  <= bus.clken & (cnt_nxt == FULL_CNT);
    end
  end

  assign bus.win_pixel = win;
  assign bus.fill_cnt  = cnt;
  assign bus.win_full  = full;
  assign bus.win_valid = vld;
endmodule
